// File: rtl/bat_pkg.sv
// Purpose: shared constants for the BatAmateur RAM arbiter (FSM encoding, port ids).
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: ST_* state codes for the arbiter FSM, PORT_* ids used for OWNER and the picker.
package bat_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/bat_mem_arbiter_if.sv
// Purpose: one requester's RAM access channel (request fields, grant, read response).
// Latency: n/a (wiring only).
// Backpressure: req is held with its fields stable until gnt pulses.
// Ports: req/lock/we/addr/wdata from requester; gnt/rvalid/rdata back from arbiter.
interface bat_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    import bat_pkg::*;

    logic          req;
    logic          lock;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/bat_rr_pick.sv
// Purpose: combinational 2-way round-robin picker with lock override.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid low when no port requests.
// Ports: req[1:0] (bit index = port id), last winner, lock_port/lock_active -> valid, winner.
module bat_rr_pick
    import bat_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_port,
    input  logic       lock_active,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        // A live lock only holds while the locked port keeps requesting.
        if (lock_active && req[lock_port]) begin
            winner = lock_port;
        end else if (req == 2'b11) begin
            winner = ~last;
        end else if (req[PORT_DMA]) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/bat_mem_arbiter.sv
// Purpose: shares the single-ported program/data RAM between the CPU and DMA ports.
// Latency: req seen in cycle A -> gnt + RAM_EN in A+1 -> rvalid in A+2; back-to-back every 2 cycles.
// Backpressure: requester holds req until gnt; loser waits one access, or MAX_LOCK if the other is locked.
// Ports: CLK, RST (sync, active-low); cpu/dma request channels; RAM_* strobe/address/data; OWNER, BUSY.
module bat_mem_arbiter
    import bat_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    bat_mem_arbiter_if.slave     cpu,
    bat_mem_arbiter_if.slave     dma,
    output logic                 RAM_EN,
    output logic                 RAM_WE,
    output logic [AW-1:0]        RAM_ADDR,
    output logic [DW-1:0]        RAM_WDATA,
    input  logic [DW-1:0]        RAM_RDATA,
    output logic                 OWNER,
    output logic                 BUSY
);

    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    logic [1:0]    state;
    logic          last;
    logic          lock_act;
    logic [3:0]    lock_cnt;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;

    logic [1:0]    req;
    logic          lock_live;
    logic          owner_lock;
    logic          pick_vld;
    logic          pick_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign req = {dma.req, cpu.req};

    // An exhausted lock is ignored for exactly one arbitration; the
    // counter clears in that same arbitration.
    assign lock_live  = lock_act && (lock_cnt < LOCK_MAX);
    assign owner_lock = (OWNER == PORT_DMA) ? dma.lock : cpu.lock;

    bat_rr_pick u_pick (
        .req         (req),
        .last        (last),
        .lock_port   (OWNER),
        .lock_active (lock_live),
        .valid       (pick_vld),
        .winner      (pick_port)
    );

    assign sel_we    = (pick_port == PORT_DMA) ? dma.we    : cpu.we;
    assign sel_addr  = (pick_port == PORT_DMA) ? dma.addr  : cpu.addr;
    assign sel_wdata = (pick_port == PORT_DMA) ? dma.wdata : cpu.wdata;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rvalid    <= '0;
            RAM_EN    <= 1'b0;
            RAM_WE    <= 1'b0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            OWNER     <= PORT_CPU;
            BUSY      <= 1'b0;
            last      <= PORT_DMA;
            lock_act  <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            RAM_EN <= 1'b0;
            RAM_WE <= 1'b0;
            if (state == ST_ACCESS) begin
                state         <= ST_DONE;
                BUSY          <= 1'b1;
                // RAM_WE still holds the issued access type here.
                rvalid[OWNER] <= ~RAM_WE;
                if (owner_lock) begin
                    lock_act <= 1'b1;
                    lock_cnt <= lock_cnt + 4'd1;
                end else begin
                    lock_act <= 1'b0;
                    lock_cnt <= '0;
                end
            end else begin
                // IDLE and DONE both arbitrate; the lock is re-sampled in
                // the following ACCESS, so it never outlives one decision.
                lock_act <= 1'b0;
                if (!(lock_live && req[OWNER])) begin
                    lock_cnt <= '0;
                end
                if (pick_vld) begin
                    state          <= ST_ACCESS;
                    BUSY           <= 1'b1;
                    OWNER          <= pick_port;
                    last           <= pick_port;
                    gnt[pick_port] <= 1'b1;
                    RAM_EN         <= 1'b1;
                    RAM_WE         <= sel_we;
                    RAM_ADDR       <= sel_addr;
                    RAM_WDATA      <= sel_wdata;
                end else begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            end
        end
    end

    assign cpu.gnt    = gnt[PORT_CPU];
    assign dma.gnt    = gnt[PORT_DMA];
    assign cpu.rvalid = rvalid[PORT_CPU];
    assign dma.rvalid = rvalid[PORT_DMA];
    assign cpu.rdata  = RAM_RDATA;
    assign dma.rdata  = RAM_RDATA;

endmodule

// File: tb/tb_bat_mem_arbiter.sv
// Purpose: self-checking bench for bat_mem_arbiter with a synchronous-read RAM model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters hold req until gnt, as the arbiter expects.
module tb_bat_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RAM_EN, RAM_WE, OWNER, BUSY;
    logic [7:0]  RAM_ADDR;
    logic [15:0] RAM_WDATA;
    logic [15:0] RAM_RDATA;

    int n_tests = 0;
    int n_fail  = 0;

    bat_mem_arbiter_if #(.AW(8), .DW(16)) cpu_if ();
    bat_mem_arbiter_if #(.AW(8), .DW(16)) dma_if ();

    bat_mem_arbiter #(.AW(8), .DW(16), .MAX_LOCK(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cpu       (cpu_if),
        .dma       (dma_if),
        .RAM_EN    (RAM_EN),
        .RAM_WE    (RAM_WE),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_WDATA (RAM_WDATA),
        .RAM_RDATA (RAM_RDATA),
        .OWNER     (OWNER),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // RAM model: unwritten words return a fixed preload pattern.
    logic [15:0]  mem [256];
    logic [255:0] wr_vld = '0;

    function automatic logic [15:0] preload(input logic [7:0] a);
        case (a)
            8'h10:   preload = 16'hBEEF;
            8'h30:   preload = 16'h3030;
            8'h31:   preload = 16'h3131;
            default: preload = {8'hA5, a};
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) begin
                mem[RAM_ADDR]    <= RAM_WDATA;
                wr_vld[RAM_ADDR] <= 1'b1;
            end
            RAM_RDATA <= wr_vld[RAM_ADDR] ? mem[RAM_ADDR] : preload(RAM_ADDR);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_if.req = 1'b0; cpu_if.lock = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        dma_if.req = 1'b0; dma_if.lock = 1'b0; dma_if.we = 1'b0; dma_if.addr = '0; dma_if.wdata = '0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    // exp holds 2 bits per cycle, {dma_gnt, cpu_gnt}, cycle 1 in the LSBs.
    task automatic gnt_seq(input string nm, input int n, input logic [31:0] exp);
        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
            chk($sformatf("%s c%0d gnt", nm, c + 1), {30'd0, dma_if.gnt, cpu_if.gnt}, {30'd0, exp[2*c +: 2]});
        end
    endtask

    // Index 0 = CPU, 1 = DMA. Expected values describe outputs after the edge.
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  caddr;
        logic [7:0]  daddr;
        logic [15:0] dwd;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic        en;
        logic        rwe;
        logic [7:0]  raddr;
        logic [15:0] rwdata;
        logic        owner;
        logic        busy;
        logic [15:0] rd;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            req    we     caddr  daddr  dwd       gnt    rv     en    rwe   raddr  rwdata    own   busy  rd
        vt[0]  = '{2'b01, 2'b00, 8'h10, 8'h00, 16'h0000, 2'b01, 2'b00, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vt[1]  = '{2'b00, 2'b00, 8'h10, 8'h00, 16'h0000, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
        vt[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vt[3]  = '{2'b10, 2'b10, 8'h00, 8'h20, 16'h1234, 2'b10, 2'b00, 1'b1, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b1, 16'h0000};
        vt[4]  = '{2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vt[5]  = '{2'b01, 2'b00, 8'h20, 8'h00, 16'h0000, 2'b01, 2'b00, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vt[6]  = '{2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vt[7]  = '{2'b11, 2'b00, 8'h30, 8'h31, 16'h0000, 2'b10, 2'b00, 1'b1, 1'b0, 8'h31, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vt[8]  = '{2'b01, 2'b00, 8'h30, 8'h00, 16'h0000, 2'b00, 2'b10, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 16'h3131};
        vt[9]  = '{2'b01, 2'b00, 8'h30, 8'h00, 16'h0000, 2'b01, 2'b00, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vt[10] = '{2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h3030};
        vt[11] = '{2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000};

        // Reset state.
        do_reset();
        chk("rst gnt",    {30'd0, dma_if.gnt, cpu_if.gnt},       32'd0);
        chk("rst rvalid", {30'd0, dma_if.rvalid, cpu_if.rvalid}, 32'd0);
        chk("rst ram_en", {31'd0, RAM_EN},    32'd0);
        chk("rst ram_we", {31'd0, RAM_WE},    32'd0);
        chk("rst addr",   {24'd0, RAM_ADDR},  32'd0);
        chk("rst wdata",  {16'd0, RAM_WDATA}, 32'd0);
        chk("rst owner",  {31'd0, OWNER},     32'd0);
        chk("rst busy",   {31'd0, BUSY},      32'd0);

        // Directed table: single read, write, read-back, tie after CPU win.
        for (int i = 0; i < NV; i++) begin
            cpu_if.req  = vt[i].req[0]; dma_if.req  = vt[i].req[1];
            cpu_if.we   = vt[i].we[0];  dma_if.we   = vt[i].we[1];
            cpu_if.addr = vt[i].caddr;  dma_if.addr = vt[i].daddr;
            dma_if.wdata = vt[i].dwd;
            @(posedge CLK); #1;
            chk($sformatf("row%0d gnt", i),    {30'd0, dma_if.gnt, cpu_if.gnt},       {30'd0, vt[i].gnt});
            chk($sformatf("row%0d rvalid", i), {30'd0, dma_if.rvalid, cpu_if.rvalid}, {30'd0, vt[i].rv});
            chk($sformatf("row%0d ram_en", i), {31'd0, RAM_EN}, {31'd0, vt[i].en});
            chk($sformatf("row%0d owner", i),  {31'd0, OWNER},  {31'd0, vt[i].owner});
            chk($sformatf("row%0d busy", i),   {31'd0, BUSY},   {31'd0, vt[i].busy});
            if (vt[i].en) begin
                chk($sformatf("row%0d ram_addr", i), {24'd0, RAM_ADDR}, {24'd0, vt[i].raddr});
                chk($sformatf("row%0d ram_we", i),   {31'd0, RAM_WE},   {31'd0, vt[i].rwe});
            end
            if (vt[i].rwe) begin
                chk($sformatf("row%0d ram_wdata", i), {16'd0, RAM_WDATA}, {16'd0, vt[i].rwdata});
            end
            if (vt[i].rv[1]) begin
                chk($sformatf("row%0d dma_rdata", i), {16'd0, dma_if.rdata}, {16'd0, vt[i].rd});
            end
            if (vt[i].rv[0]) begin
                chk($sformatf("row%0d cpu_rdata", i), {16'd0, cpu_if.rdata}, {16'd0, vt[i].rd});
            end
        end

        // Tie after reset: CPU, DMA, CPU, DMA every other cycle.
        do_reset();
        cpu_if.req = 1'b1; cpu_if.addr = 8'h40;
        dma_if.req = 1'b1; dma_if.addr = 8'h41;
        gnt_seq("tie", 8, 32'b0010_0001_0010_0001);

        // Lock bound: 4 CPU grants, 1 DMA grant, then CPU again.
        do_reset();
        cpu_if.req = 1'b1; cpu_if.lock = 1'b1; cpu_if.addr = 8'h50;
        dma_if.req = 1'b1; dma_if.addr = 8'h51;
        gnt_seq("lock", 12, 32'b0001_0010_0001_0001_0001_0001);

        // Reset in the ACCESS cycle of a CPU read.
        do_reset();
        cpu_if.req = 1'b1; cpu_if.addr = 8'h10;
        @(posedge CLK); #1;
        chk("midrst gnt before", {31'd0, cpu_if.gnt}, 32'd1);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst gnt",    {30'd0, dma_if.gnt, cpu_if.gnt},       32'd0);
        chk("midrst rvalid", {30'd0, dma_if.rvalid, cpu_if.rvalid}, 32'd0);
        chk("midrst en_we",  {30'd0, RAM_EN, RAM_WE}, 32'd0);
        chk("midrst addr",   {24'd0, RAM_ADDR},       32'd0);
        chk("midrst own_busy", {30'd0, OWNER, BUSY},  32'd0);
        RST = 1'b1;
        cpu_if.req = 1'b0;
        @(posedge CLK); #1;
        chk("midrst no rvalid", {31'd0, cpu_if.rvalid}, 32'd0);
        chk("midrst busy after", {31'd0, BUSY}, 32'd0);
        cpu_if.req = 1'b1; dma_if.req = 1'b1;
        @(posedge CLK); #1;
        chk("midrst tie", {30'd0, dma_if.gnt, cpu_if.gnt}, 32'd1);

        // Locked CPU withdraws its request in DONE while DMA waits.
        do_reset();
        cpu_if.req = 1'b1; cpu_if.lock = 1'b1; cpu_if.addr = 8'h60;
        dma_if.req = 1'b1; dma_if.addr = 8'h61;
        @(posedge CLK); #1;
        chk("wd first gnt", {30'd0, dma_if.gnt, cpu_if.gnt}, 32'd1);
        @(posedge CLK); #1;
        chk("wd cpu rvalid", {31'd0, cpu_if.rvalid}, 32'd1);
        cpu_if.req = 1'b0; cpu_if.lock = 1'b0;
        @(posedge CLK); #1;
        chk("wd dma gnt", {30'd0, dma_if.gnt, cpu_if.gnt}, 32'd2);
        chk("wd lock_cnt", {28'd0, dut.lock_cnt}, 32'd0);
        dma_if.req = 1'b0;
        cpu_if.req = 1'b1;
        @(posedge CLK); #1;
        chk("wd dma rvalid", {31'd0, dma_if.rvalid}, 32'd1);
        @(posedge CLK); #1;
        chk("wd cpu regrant", {30'd0, dma_if.gnt, cpu_if.gnt}, 32'd1);

        idle_inputs();
        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
